// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op encodings and sideband type for the pipelined shifter
//
// Purpose: types and constants shared by shifter_pipe and shift_stage.
//   shift_op_t        : 2-bit operation code (SLL, SRL, SRA, ROTL).
//   shift_sideband_t  : control bits that travel alongside the data through
//                       every register slice (op, shamt, sign, tag).
// The sideband fields are sized for the largest supported configuration
// (WIDTH up to 64, tag up to 16 bits); narrower builds zero-extend into them.
// Optional feature macro used by this bundle: SHIFTER_ROTATE_EN.

package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTL = 2'b11
    } shift_op_t;

    // Upper bounds for the sideband fields; WIDTH <= 64 gives shamt <= 6 bits.
    localparam int MAX_SHAMT_W = 6;
    localparam int MAX_TAG_W   = 16;

    typedef struct packed {
        shift_op_t              op;
        logic [MAX_SHAMT_W-1:0] shamt;
        logic                   sign;   // operand MSB captured at entry, used as SRA fill
        logic [MAX_TAG_W-1:0]   tag;
    } shift_sideband_t;

    localparam shift_sideband_t SIDEBAND_RESET = '{
        op:    OP_SLL,
        shamt: '0,
        sign:  1'b0,
        tag:   '0
    };

    // Build the entry sideband from raw port values (zero-extending shamt/tag).
    function automatic shift_sideband_t make_sideband(
        input logic [1:0]             op,
        input logic [MAX_SHAMT_W-1:0] shamt,
        input logic                   sign,
        input logic [MAX_TAG_W-1:0]   tag
    );
        shift_sideband_t sb;
        sb       = SIDEBAND_RESET;
        sb.op    = shift_op_t'(op);
        sb.shamt = shamt;
        sb.sign  = sign;
        sb.tag   = tag;
        return sb;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one fixed-distance barrel shifter stage (combinational)
//
// Purpose: shifts 'data' by the constant AMT when 'sel' is 1, else passes it.
// Ports:
//   data   [WIDTH] in  : stage operand
//   op             in  : operation code (shift_op_t)
//   sign           in  : original operand MSB, used as SRA fill
//   sel            in  : this stage's shift-amount bit
//   result [WIDTH] out : shifted or passed-through operand
// Macro SHIFTER_ROTATE_EN: when undefined, ROTL falls back to zero-fill SLL.

module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data,
    input  shift_op_t        op,
    input  logic             sign,
    input  logic             sel,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = data;
        case (op)
            OP_SLL:  shifted = {data[WIDTH-AMT-1:0], {AMT{1'b0}}};
            OP_SRL:  shifted = {{AMT{1'b0}}, data[WIDTH-1:AMT]};
            // Fill comes from the carried sign, not this stage's MSB, so the
            // fill is correct regardless of which earlier stages were taken.
            OP_SRA:  shifted = {{AMT{sign}}, data[WIDTH-1:AMT]};
`ifdef SHIFTER_ROTATE_EN
            OP_ROTL: shifted = {data[WIDTH-AMT-1:0], data[WIDTH-1:WIDTH-AMT]};
`else
            OP_ROTL: shifted = {data[WIDTH-AMT-1:0], {AMT{1'b0}}};
`endif
            default: shifted = data;
        endcase
    end

    assign result = sel ? shifted : data;

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined multi-mode barrel shifter with valid/ready handshake
//
// Purpose: SLL / SRL / SRA / ROTL of a WIDTH-bit operand by 0..WIDTH-1, built
// from SHAMT_W log2 stages (largest distance first). PIPE=1 registers every
// stage (latency SHAMT_W); PIPE=0 keeps the stages combinational and adds one
// output register (latency 1). A stalled output freezes the whole pipe.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   in_valid/in_ready       : input handshake
//   in_data, in_shamt,
//   in_op, in_tag           : operand, shift amount, op code, sideband tag
//   out_valid/out_ready     : output handshake
//   out_data, out_tag       : result and its tag
// Macro SHIFTER_ROTATE_EN: enables rotate-left for op 11 (else op 11 == SLL).
// Supported: WIDTH power of two in 8..64, TAG_W <= 16.

module shifter_pipe
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 5,
    parameter  int PIPE    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    shift_sideband_t  in_sb;
    logic             stall;
    logic             final_valid;
    logic [WIDTH-1:0] final_data;
    shift_sideband_t  final_sb;

    assign in_sb = make_sideband(in_op,
                                 MAX_SHAMT_W'(in_shamt),
                                 in_data[WIDTH-1],
                                 MAX_TAG_W'(in_tag));

    // Only the last stage can be blocked; everything upstream freezes with it.
    assign stall    = final_valid && !out_ready;
    assign in_ready = !stall;

    // Stage i handles shift distance 2^K with K = SHAMT_W-1-i.
    // d_nxt/sb_nxt/v_nxt are the stage's hand-off to stage i+1: registered
    // when PIPE=1, a straight wire when PIPE=0.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int K = SHAMT_W - 1 - i;

        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_out;
        logic [WIDTH-1:0] d_nxt;
        shift_sideband_t  sb_in;
        shift_sideband_t  sb_nxt;
        logic             v_in;
        logic             v_nxt;

        if (i == 0) begin : g_head
            assign d_in  = in_data;
            assign sb_in = in_sb;
            assign v_in  = in_valid;
        end else begin : g_link
            assign d_in  = g_stage[i-1].d_nxt;
            assign sb_in = g_stage[i-1].sb_nxt;
            assign v_in  = g_stage[i-1].v_nxt;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << K)
        ) u_shift (
            .data   (d_in),
            .op     (sb_in.op),
            .sign   (sb_in.sign),
            .sel    (sb_in.shamt[K]),
            .result (d_out)
        );

        if (PIPE != 0) begin : g_reg
            always_ff @(posedge clock) begin
                if (reset) begin
                    v_nxt  <= 1'b0;
                    d_nxt  <= '0;
                    sb_nxt <= SIDEBAND_RESET;
                end else if (!stall) begin
                    v_nxt  <= v_in;
                    d_nxt  <= d_out;
                    sb_nxt <= sb_in;
                end
            end
        end else begin : g_comb
            assign v_nxt  = v_in;
            assign d_nxt  = d_out;
            assign sb_nxt = sb_in;
        end
    end

    if (PIPE != 0) begin : g_out_pipe
        // Last stage's slice is the output register.
        assign final_valid = g_stage[SHAMT_W-1].v_nxt;
        assign final_data  = g_stage[SHAMT_W-1].d_nxt;
        assign final_sb    = g_stage[SHAMT_W-1].sb_nxt;
    end else begin : g_out_reg
        always_ff @(posedge clock) begin
            if (reset) begin
                final_valid <= 1'b0;
                final_data  <= '0;
                final_sb    <= SIDEBAND_RESET;
            end else if (!stall) begin
                final_valid <= g_stage[SHAMT_W-1].v_nxt;
                final_data  <= g_stage[SHAMT_W-1].d_nxt;
                final_sb    <= g_stage[SHAMT_W-1].sb_nxt;
            end
        end
    end

    assign out_valid = final_valid;
    assign out_data  = final_data;
    assign out_tag   = final_sb.tag[TAG_W-1:0];

    // op/shamt/sign and the upper tag bits are spent by the time they reach
    // the output; fold them into one sink so they do not dangle.
    logic unused_final_sb;
    assign unused_final_sb = ^final_sb;

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - self-checking bench for shifter_pipe (PIPE=1 and PIPE=0)

module tb_shifter_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [4:0]  in_shamt  [2];
    logic [1:0]  in_op     [2];
    logic [4:0]  in_tag    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic [4:0]  out_tag   [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    shifter_pipe #(.WIDTH(32), .TAG_W(5), .PIPE(1)) u_dut_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_shamt  (in_shamt[0]),
        .in_op     (in_op[0]),
        .in_tag    (in_tag[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .out_tag   (out_tag[0])
    );

    shifter_pipe #(.WIDTH(32), .TAG_W(5), .PIPE(0)) u_dut_comb (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_shamt  (in_shamt[1]),
        .in_op     (in_op[1]),
        .in_tag    (in_tag[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .out_tag   (out_tag[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the operand.
    function automatic logic [31:0] model(input logic [31:0] d, input int s, input int op);
        logic [31:0] r;
        case (op)
            0: r = d << s;
            1: r = d >> s;
            2: r = 32'($signed(d) >>> s);
`ifdef SHIFTER_ROTATE_EN
            default: r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
`else
            default: r = d << s;
`endif
        endcase
        return r;
    endfunction

    task automatic run_directed(input int sel, input logic [31:0] d, input int s,
                                input int op, input int tag, input logic [31:0] exp);
        int n;
        int lat;
        lat = (sel == 0) ? 5 : 1;
        @(posedge clock); #1;
        in_valid[sel]  = 1'b1;
        in_data[sel]   = d;
        in_shamt[sel]  = 5'(s);
        in_op[sel]     = 2'(op);
        in_tag[sel]    = 5'(tag);
        out_ready[sel] = 1'b1;
        @(negedge clock);
        check("dir_in_ready", 64'(in_ready[sel]), 64'd1);
        @(posedge clock); #1;
        in_valid[sel] = 1'b0;
        n = 1;
        @(negedge clock);
        while (!out_valid[sel] && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("dir_latency", 64'(n), 64'(lat));
        check("dir_data", 64'(out_data[sel]), 64'(exp));
        check("dir_tag", 64'(out_tag[sel]), 64'(tag));
        @(negedge clock);
        check("dir_drain", 64'(out_valid[sel]), 64'd0);
    endtask

    // b2b=1: ops every cycle, out_ready low on cycles 6..8. b2b=0: random traffic.
    task automatic stream(input int sel, input int n_ops, input bit b2b);
        logic [31:0] qd[$];
        logic [4:0]  qt[$];
        int          issued = 0;
        int          delivered = 0;
        int          cyc = 0;
        bit          pend = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_d = '0;
        logic [4:0]  prev_t = '0;
        bit          stall;
        while ((issued < n_ops || pend || qd.size() > 0) && cyc < 4000) begin
            @(posedge clock); #1;
            cyc++;
            if (b2b) out_ready[sel] = !(cyc >= 6 && cyc <= 8);
            else     out_ready[sel] = ($urandom_range(0, 3) != 0);
            if (!pend && issued < n_ops && (b2b || $urandom_range(0, 9) < 7)) begin
                in_valid[sel] = 1'b1;
                in_data[sel]  = $urandom;
                in_shamt[sel] = 5'($urandom_range(0, 31));
                in_op[sel]    = 2'($urandom_range(0, 3));
                in_tag[sel]   = 5'($urandom_range(0, 31));
                pend = 1;
            end else if (!pend) begin
                in_valid[sel] = 1'b0;
            end
            @(negedge clock);
            stall = out_valid[sel] && !out_ready[sel];
            if (b2b) check("b2b_in_ready", 64'(in_ready[sel]), 64'(!(cyc >= 6 && cyc <= 8)));
            else     check("str_in_ready", 64'(in_ready[sel]), 64'(!stall));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid[sel]), 64'd1);
                check("stall_data", 64'(out_data[sel]), 64'(prev_d));
                check("stall_tag", 64'(out_tag[sel]), 64'(prev_t));
            end
            if (out_valid[sel] && out_ready[sel]) begin
                if (qd.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    check("str_data", 64'(out_data[sel]), 64'(qd.pop_front()));
                    check("str_tag", 64'(out_tag[sel]), 64'(qt.pop_front()));
                    delivered++;
                end
            end
            if (in_valid[sel] && in_ready[sel]) begin
                qd.push_back(model(in_data[sel], int'(in_shamt[sel]), int'(in_op[sel])));
                qt.push_back(in_tag[sel]);
                issued++;
                pend = 0;
            end
            prev_stall = stall;
            prev_d = out_data[sel];
            prev_t = out_tag[sel];
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b1;
        check("str_timeout", 64'(cyc >= 4000), 64'd0);
        check("str_delivered", 64'(delivered), 64'(n_ops));
    endtask

    task automatic reset_midflight(input int sel);
        int seen = 0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clock); #1;
            in_valid[sel]  = 1'b1;
            in_data[sel]   = $urandom;
            in_shamt[sel]  = 5'($urandom_range(0, 31));
            in_op[sel]     = 2'($urandom_range(0, 3));
            in_tag[sel]    = 5'($urandom_range(1, 31));
            out_ready[sel] = 1'b1;
        end
        @(posedge clock); #1;
        in_valid[sel] = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid[sel]), 64'd0);
        check("rst_out_data", 64'(out_data[sel]), 64'd0);
        check("rst_out_tag", 64'(out_tag[sel]), 64'd0);
        check("rst_in_ready", 64'(in_ready[sel]), 64'd1);
        repeat (12) begin
            @(negedge clock);
            if (out_valid[sel]) seen++;
        end
        check("rst_none_emerge", 64'(seen), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rot1;
        logic [31:0] rot31;
`ifdef SHIFTER_ROTATE_EN
        rot1  = 32'h0000_0003;
        rot31 = 32'hC000_0000;
`else
        rot1  = 32'h0000_0002;
        rot31 = 32'h8000_0000;
`endif
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = '0;
            in_shamt[s]  = '0;
            in_op[s]     = '0;
            in_tag[s]    = '0;
            out_ready[s] = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check("init_out_valid", 64'(out_valid[s]), 64'd0);
            check("init_out_data", 64'(out_data[s]), 64'd0);
            check("init_out_tag", 64'(out_tag[s]), 64'd0);
            check("init_in_ready", 64'(in_ready[s]), 64'd1);
        end

        for (int s = 0; s < 2; s++) begin
            run_directed(s, 32'h0000_00F1, 4, 0, 7, 32'h0000_0F10);
            run_directed(s, 32'h8000_0010, 4, 2, 3, 32'hF800_0001);
            run_directed(s, 32'h8000_0010, 4, 1, 4, 32'h0800_0001);
            run_directed(s, 32'h8000_0001, 1, 3, 9, rot1);
            run_directed(s, 32'h8000_0001, 31, 3, 10, rot31);
            run_directed(s, 32'hFFFF_FFFF, 31, 0, 1, 32'h8000_0000);
            run_directed(s, 32'h8000_0000, 31, 2, 2, 32'hFFFF_FFFF);
            run_directed(s, 32'h8000_0000, 31, 1, 5, 32'h0000_0001);
            for (int op = 0; op < 4; op++)
                run_directed(s, 32'hA5C3_0F96, 0, op, 20 + op, 32'hA5C3_0F96);
            stream(s, 8, 1'b1);
            stream(s, 200, 1'b0);
            reset_midflight(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined multi-mode barrel shifter with valid/ready handshake. It supports logical left, logical right, arithmetic right and optional rotate-left. It replaces the single-cycle combinational left shifter in the ALU shift path. Each log2 stage can be registered, so the shift unit can be retimed to meet the processor clock, and back-pressure from the writeback stage is honoured.

## Interface
Parameters:
- WIDTH, 32: data width; power of two, 8 to 64.
- SHAMT_W, $clog2(WIDTH): localparam; shift-amount width.
- TAG_W, 5: width of the sideband tag (destination register index) carried with each operation.
- PIPE, 1: 1 = register after every log2 stage; 0 = combinational stages followed by one output register.

Ports:
- clock, input, 1: single clock; all state on rising edge.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: operation accepted when in_valid && in_ready.
- in_data, input, WIDTH: operand.
- in_shamt, input, SHAMT_W: shift amount, 0 to WIDTH-1.
- in_op, input, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROTL.
- in_tag, input, TAG_W: passed through unchanged.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result when out_valid && out_ready.
- out_data, output, WIDTH: shifted result.
- out_tag, output, TAG_W: tag of the result.

## Operation
- Stages are indexed k = SHAMT_W-1 down to 0. Stage k shifts by 2^k when shamt bit k is 1, and otherwise passes its input through.
- Fill rules:
  - SLL: zeros fill from the LSB side.
  - SRL: zeros fill from the MSB side.
  - SRA: the operand's original MSB is replicated. The sign bit is captured at input and carried down the pipe.
  - ROTL: bits shifted out at the MSB re-enter at the LSB.
- shamt, op, tag and the sign bit travel with the data through each register slice.
- shamt = 0 returns in_data unmodified for every op.
- There is no arithmetic overflow or flag output.

## Timing
- Latency L = SHAMT_W when PIPE=1 (5 cycles at WIDTH=32), and L = 1 when PIPE=0.
- Throughput is one operation per cycle when out_ready is held high.
- Stall rule: stall = out_valid && !out_ready; in_ready = !stall.
  - During stall, every pipeline register (valid, data, sideband) holds its value.
  - Bubbles are not compressed; the whole pipe freezes.
- out_data and out_tag stay stable while out_valid && !out_ready.
- Reset (synchronous): all stage valid bits become 0, and all data and tag registers become 0.
  - Resulting outputs: out_valid=0, out_data=0, out_tag=0, in_ready=1 in the cycle after reset is sampled.
  - Reset mid-operation discards all in-flight operations; none emerge.
- Operations enter on in_valid && in_ready, including in a cycle where a result leaves simultaneously. There is no extra bubble.
- in_valid with in_ready=0 is not captured. The producer must hold its inputs.
- out_valid && out_ready with no new input: the final-stage valid becomes 0 after one cycle, provided the upstream stage is empty.

## Configuration
- Macro SHIFTER_ROTATE_EN.
- Defined: op 11 performs rotate-left, as described above.
- Undefined: rotate wrap logic is not built, and op 11 produces the same result as SLL (zero fill). No error indication.

## Structure
- Shared package shifter_pkg holds:
  - the op encodings as an enum: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROTL=2'b11;
  - a shift_sideband_t struct {op, shamt, sign, tag}.
- Sub-module shift_stage, parameterised by WIDTH and AMT = 2^k. It is combinational: one fixed-distance shift for all four op fill rules, plus a 2:1 select on its shamt bit.
- shifter_pipe instantiates SHAMT_W copies of shift_stage via generate. It also generates the optional register slice, depending on PIPE.

## Test plan
- SLL, WIDTH=32, PIPE=1: in_data=0x0000_00F1, shamt=4, op=00, tag=7 -> after 5 cycles out_data=0x0000_0F10, out_tag=7.
- SRA: in_data=0x8000_0010, shamt=4 -> out_data=0xF800_0001. The same input with SRL -> 0x0800_0001.
- ROTL with SHIFTER_ROTATE_EN: in_data=0x8000_0001, shamt=1 -> 0x0000_0003. Without the macro -> 0x0000_0002.
- Back-to-back stream: 8 ops on consecutive cycles, with out_ready low on cycles 6–8.
  - Required: in_ready low exactly while stalled.
  - Required: all 8 results are delivered in order with correct tags, with no loss or duplication.
- Reset mid-flight: 3 ops issued, then reset asserted for one cycle -> out_valid=0, out_data=0, in_ready=1 next cycle. None of the 3 results ever appear.
- Boundaries:
  - shamt=0 for all ops returns in_data.
  - shamt=31 SLL on 0xFFFF_FFFF -> 0x8000_0000; SRA on 0x8000_0000 -> 0xFFFF_FFFF.
  - Repeat with PIPE=0: latency 1.
